// File: rtl/game_state_ctrl_pkg.sv
// Shared types, field widths and default game constants for the game-level controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        HIT_PAUSE,
        WIN,
        LOSE
    } game_state_t;

    localparam int LIVES_W  = 2;
    localparam int ALIENS_W = 6;
    localparam int SCORE_W  = 16;
    localparam int FRAME_W  = 9;

    localparam int DEF_NUM_ALIENS       = 55;
    localparam int DEF_START_LIVES      = 3;
    localparam int DEF_POINTS_PER_ALIEN = 10;
    localparam int DEF_PAUSE_FRAMES     = 90;
    localparam int DEF_BANNER_FRAMES    = 360;

endpackage

// File: rtl/game_state_ctrl_frame_timer.sv
// Frame down-counter shared by the hit pause and the win/lose banner hold.
module frame_timer
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_val,
    input  logic               vsync_tick,
    output logic               done
);

    logic [FRAME_W-1:0] count;

    // A load wins over a coincident tick, so the entry frame is never counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (vsync_tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// Game-level FSM: tracks lives, aliens and score, and drives the banner and freeze flags.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int NUM_ALIENS       = DEF_NUM_ALIENS,
    parameter int START_LIVES      = DEF_START_LIVES,
    parameter int POINTS_PER_ALIEN = DEF_POINTS_PER_ALIEN,
    parameter int PAUSE_FRAMES     = DEF_PAUSE_FRAMES,
    parameter int BANNER_FRAMES    = DEF_BANNER_FRAMES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vsync_tick,
    input  logic                start_btn,
    input  logic                alien_hit,
    input  logic                player_hit,
    input  logic                invasion,
    output logic                game_active,
    output logic                freeze,
    output logic                winner,
    output logic                loser,
    output logic [LIVES_W-1:0]  lives,
    output logic [ALIENS_W-1:0] aliens_left,
    output logic [SCORE_W-1:0]  score
);

    game_state_t        state;
    game_state_t        next_state;
    logic               start_q;
    logic               start_edge;
    logic               timer_load;
    logic [FRAME_W-1:0] timer_val;
    logic               timer_done;
    logic               game_active_d;
    logic               freeze_d;
    logic               winner_d;
    logic               loser_d;

    function automatic logic [SCORE_W-1:0] add_sat_score(input logic [SCORE_W-1:0] a);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W+1)'(POINTS_PER_ALIEN);
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [ALIENS_W-1:0] dec_sat_aliens(input logic [ALIENS_W-1:0] a);
        return (a == '0) ? '0 : a - 1'b1;
    endfunction

    function automatic logic [LIVES_W-1:0] dec_sat_lives(input logic [LIVES_W-1:0] a);
        return (a == '0) ? '0 : a - 1'b1;
    endfunction

    // Resetting the edge register to 1 stops a button held through reset from starting a game.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start_btn;
        end
    end

    assign start_edge = start_btn && !start_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_edge) next_state = PLAY;
            end
            PLAY: begin
                if (invasion || (player_hit && (lives == LIVES_W'(1)))) begin
                    next_state = LOSE;
                end else if (alien_hit && (aliens_left == ALIENS_W'(1))) begin
                    next_state = WIN;
                end else if (player_hit) begin
                    next_state = HIT_PAUSE;
                end
            end
            HIT_PAUSE: begin
                if (timer_done) next_state = PLAY;
            end
            WIN, LOSE: begin
                if (timer_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Every timed state is entered from PLAY, so the timer loads on any exit from PLAY.
    assign timer_load = (state == PLAY) && (next_state != PLAY);
    assign timer_val  = (next_state == HIT_PAUSE) ? FRAME_W'(PAUSE_FRAMES)
                                                  : FRAME_W'(BANNER_FRAMES);

    frame_timer u_frame_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_val   (timer_val),
        .vsync_tick (vsync_tick),
        .done       (timer_done)
    );

    always_comb begin
        game_active_d = (next_state == PLAY) || (next_state == HIT_PAUSE);
        freeze_d      = (next_state == HIT_PAUSE);
        winner_d      = (next_state == WIN);
        loser_d       = (next_state == LOSE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            game_active <= 1'b0;
            freeze      <= 1'b0;
            winner      <= 1'b0;
            loser       <= 1'b0;
        end else begin
            game_active <= game_active_d;
            freeze      <= freeze_d;
            winner      <= winner_d;
            loser       <= loser_d;
        end
    end

    // Counters only move in PLAY; banners and IDLE keep the last values on display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lives       <= '0;
            aliens_left <= '0;
            score       <= '0;
        end else if ((state == IDLE) && start_edge) begin
            lives       <= LIVES_W'(START_LIVES);
            aliens_left <= ALIENS_W'(NUM_ALIENS);
            score       <= '0;
        end else if (state == PLAY) begin
            if (alien_hit) begin
                aliens_left <= dec_sat_aliens(aliens_left);
                score       <= add_sat_score(score);
            end
            if (player_hit) begin
                lives <= dec_sat_lives(lives);
            end
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: expected output words are queued with the stimulus.
module tb_game_state_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vsync_tick = 1'b0;
    logic        start_btn = 1'b1;
    logic        alien_hit = 1'b0;
    logic        player_hit = 1'b0;
    logic        invasion = 1'b0;
    logic        game_active;
    logic        freeze;
    logic        winner;
    logic        loser;
    logic [1:0]  lives;
    logic [5:0]  aliens_left;
    logic [15:0] score;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [27:0] exp;
        logic [27:0] mask;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [27:0] M_ALL   = 28'hFFF_FFFF;
    localparam logic [27:0] M_FLAGS = 28'hF00_0000;

    always #5 clk = ~clk;

    game_state_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vsync_tick  (vsync_tick),
        .start_btn   (start_btn),
        .alien_hit   (alien_hit),
        .player_hit  (player_hit),
        .invasion    (invasion),
        .game_active (game_active),
        .freeze      (freeze),
        .winner      (winner),
        .loser       (loser),
        .lives       (lives),
        .aliens_left (aliens_left),
        .score       (score)
    );

    function automatic logic [27:0] ov(input logic ga, input logic fz, input logic w,
                                       input logic l, input logic [1:0] lv,
                                       input logic [5:0] al, input logic [15:0] sc);
        return {ga, fz, w, l, lv, al, sc};
    endfunction

    function automatic logic [27:0] dut_vec();
        return {game_active, freeze, winner, loser, lives, aliens_left, score};
    endfunction

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (ga,fz,win,lose,lives,aliens,score)", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [27:0] e, input logic [27:0] m);
        exp_t x;
        x.tag  = tag;
        x.exp  = e;
        x.mask = m;
        sb_q.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check(x.tag, dut_vec() & x.mask, x.exp & x.mask);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_ticks(input int n);
        repeat (n) begin
            vsync_tick = 1'b1;
            step();
            vsync_tick = 1'b0;
            step();
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        expect_out("start", ov(1, 0, 0, 0, 2'd3, 6'd55, 16'd0), M_ALL);
        step();
        start_btn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset with the button held; no game may start until a fresh edge.
        #23;
        expect_out("reset_vals", ov(0, 0, 0, 0, 2'd0, 6'd0, 16'd0), M_ALL);
        drain();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        expect_out("held_btn_no_start", ov(0, 0, 0, 0, 2'd0, 6'd0, 16'd0), M_ALL);
        step();
        start_btn = 1'b0;
        expect_out("release_idle", ov(0, 0, 0, 0, 2'd0, 6'd0, 16'd0), M_ALL);
        step();
        press_start();

        // Clear the wave.
        for (int i = 1; i <= 55; i++) begin
            alien_hit = 1'b1;
            if (i < 55)
                expect_out("alien_hit", ov(1, 0, 0, 0, 2'd3, 6'(55 - i), 16'(10 * i)), M_ALL);
            else
                expect_out("win", ov(0, 0, 1, 0, 2'd3, 6'd0, 16'd550), M_ALL);
            step();
            alien_hit = 1'b0;
            idle(3);
        end
        send_ticks(359);
        expect_out("win_held", ov(0, 0, 1, 0, 2'd3, 6'd0, 16'd550), M_ALL);
        drain();
        send_ticks(1);
        expect_out("win_done", ov(0, 0, 0, 0, 2'd0, 6'd0, 16'd0), M_FLAGS);
        drain();

        // Non-fatal hit and the frozen pause.
        press_start();
        player_hit = 1'b1;
        expect_out("player_hit", ov(1, 1, 0, 0, 2'd2, 6'd55, 16'd0), M_ALL);
        step();
        player_hit = 1'b0;
        alien_hit = 1'b1;
        expect_out("pause_alien_ignored", ov(1, 1, 0, 0, 2'd2, 6'd55, 16'd0), M_ALL);
        step();
        alien_hit = 1'b0;
        player_hit = 1'b1;
        invasion = 1'b1;
        expect_out("pause_hit_ignored", ov(1, 1, 0, 0, 2'd2, 6'd55, 16'd0), M_ALL);
        step();
        player_hit = 1'b0;
        invasion = 1'b0;
        send_ticks(89);
        expect_out("pause_held", ov(1, 1, 0, 0, 2'd2, 6'd55, 16'd0), M_ALL);
        drain();
        send_ticks(1);
        expect_out("pause_done", ov(1, 0, 0, 0, 2'd2, 6'd55, 16'd0), M_ALL);
        drain();

        // Down to one alien and one life, then both events at once.
        for (int i = 1; i <= 54; i++) begin
            alien_hit = 1'b1;
            expect_out("alien_hit2", ov(1, 0, 0, 0, 2'd2, 6'(55 - i), 16'(10 * i)), M_ALL);
            step();
            alien_hit = 1'b0;
            idle(1);
        end
        player_hit = 1'b1;
        expect_out("second_hit", ov(1, 1, 0, 0, 2'd1, 6'd1, 16'd540), M_ALL);
        step();
        player_hit = 1'b0;
        send_ticks(90);
        expect_out("second_pause_done", ov(1, 0, 0, 0, 2'd1, 6'd1, 16'd540), M_ALL);
        drain();
        alien_hit = 1'b1;
        player_hit = 1'b1;
        expect_out("final_both_lose", ov(0, 0, 0, 1, 2'd0, 6'd0, 16'd550), M_ALL);
        step();
        alien_hit = 1'b0;
        player_hit = 1'b0;
        send_ticks(360);
        expect_out("lose_done", ov(0, 0, 0, 0, 2'd0, 6'd0, 16'd0), M_FLAGS);
        drain();

        // Invasion with full lives; start during the banner is ignored.
        press_start();
        invasion = 1'b1;
        expect_out("invasion", ov(0, 0, 0, 1, 2'd3, 6'd55, 16'd0), M_ALL);
        step();
        invasion = 1'b0;
        start_btn = 1'b1;
        expect_out("start_in_banner", ov(0, 0, 0, 1, 2'd3, 6'd55, 16'd0), M_ALL);
        step();
        start_btn = 1'b0;
        send_ticks(359);
        expect_out("lose_held", ov(0, 0, 0, 1, 2'd3, 6'd55, 16'd0), M_ALL);
        drain();
        send_ticks(1);
        expect_out("lose_done2", ov(0, 0, 0, 0, 2'd0, 6'd0, 16'd0), M_FLAGS);
        drain();

        // Asynchronous reset in the middle of a banner.
        press_start();
        invasion = 1'b1;
        expect_out("invasion2", ov(0, 0, 0, 1, 2'd3, 6'd55, 16'd0), M_ALL);
        step();
        invasion = 1'b0;
        send_ticks(100);
        rst = 1'b0;
        #2;
        expect_out("async_reset", ov(0, 0, 0, 0, 2'd0, 6'd0, 16'd0), M_ALL);
        drain();
        step();
        rst = 1'b1;
        expect_out("post_reset_idle", ov(0, 0, 0, 0, 2'd0, 6'd0, 16'd0), M_ALL);
        step();
        press_start();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
